// File: rtl/rs_issue_scheduler_pkg.sv
// Shared definitions for the ALU reservation-station scheduler: tag width,
// the "no dependency" tag, ALU opcode encodings and the entry record layout.
package rs_issue_scheduler_pkg;

  localparam int ROB_ENTRY_WIDTH = 4;
  localparam int ALU_OP_W        = 4;

  localparam logic [ROB_ENTRY_WIDTH-1:0] NO_TAG = '0;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic                       valid;
    logic [ALU_OP_W-1:0]        op;
    logic [31:0]                va;
    logic [ROB_ENTRY_WIDTH-1:0] qa;
    logic [31:0]                vb;
    logic [ROB_ENTRY_WIDTH-1:0] qb;
    logic [ROB_ENTRY_WIDTH-1:0] dest;
  } rs_entry_t;

endpackage

// File: rtl/rs_operand_slot.sv
// One operand (value + producer tag) of a station entry. The parent picks the
// source (hold, shift from neighbour, or dispatch); the CDB match is applied here.
module rs_operand_slot
  import rs_issue_scheduler_pkg::*;
#(
  parameter int TW = ROB_ENTRY_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [31:0]   src_value,
  input  logic [TW-1:0] src_tag,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [31:0]   cdb_value,
  output logic [31:0]   value_q,
  output logic [TW-1:0] tag_q,
  output logic          ready
);

  logic [31:0]   value_d;
  logic [TW-1:0] tag_d;
  logic          cdb_hit;

  // A zero broadcast tag never wakes anything, so the hit also implies src_tag != 0.
  assign cdb_hit = cdb_valid && (cdb_tag != TW'(NO_TAG)) && (src_tag == cdb_tag);

  always_comb begin
    value_d = src_value;
    tag_d   = src_tag;
    if (cdb_hit) begin
      value_d = cdb_value;
      tag_d   = TW'(NO_TAG);
    end
    if (clr) begin
      value_d = '0;
      tag_d   = TW'(NO_TAG);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      tag_q   <= TW'(NO_TAG);
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  assign ready = (tag_q == TW'(NO_TAG));

endmodule

// File: rtl/rs_issue_scheduler.sv
// ALU reservation station: age-ordered compacting queue, CDB wakeup with
// dispatch-time bypass, oldest-ready issue over a valid/ready handshake.
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int ROB_W       = ROB_ENTRY_WIDTH,
  parameter int OP_W        = ALU_OP_W,
  localparam int CW         = $clog2(NUM_ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_opa_value,
  input  logic [ROB_W-1:0] disp_opa_tag,
  input  logic [31:0]      disp_opb_value,
  input  logic [ROB_W-1:0] disp_opb_tag,
  input  logic [ROB_W-1:0] disp_rob_tag,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [OP_W-1:0]  issue_op,
  output logic [31:0]      issue_opa,
  output logic [31:0]      issue_opb,
  output logic [ROB_W-1:0] issue_rob_tag,
  output logic [CW-1:0]    occupancy
);

  localparam int N = NUM_ENTRIES;

  logic [N-1:0]     valid_q, valid_d, nb_valid, entry_rdy, a_rdy, b_rdy, dest_zero;
  logic [OP_W-1:0]  op_q [N];
  logic [OP_W-1:0]  op_d [N];
  logic [OP_W-1:0]  nb_op [N];
  logic [ROB_W-1:0] dest_q [N];
  logic [ROB_W-1:0] dest_d [N];
  logic [ROB_W-1:0] nb_dest [N];
  logic [31:0]      a_val [N];
  logic [31:0]      b_val [N];
  logic [ROB_W-1:0] a_tag [N];
  logic [ROB_W-1:0] b_tag [N];
  logic [31:0]      nb_a_val [N];
  logic [31:0]      nb_b_val [N];
  logic [ROB_W-1:0] nb_a_tag [N];
  logic [ROB_W-1:0] nb_b_tag [N];
  logic [31:0]      a_src_val [N];
  logic [31:0]      b_src_val [N];
  logic [ROB_W-1:0] a_src_tag [N];
  logic [ROB_W-1:0] b_src_tag [N];
  logic [CW-1:0]    occ_q, occ_d;

  logic             any_rdy, do_issue, do_disp;
  int               sel_idx, wr_idx;
  logic [OP_W-1:0]  sel_op;
  logic [31:0]      sel_opa, sel_opb;
  logic [ROB_W-1:0] sel_dest;

  for (genvar g = 0; g < N; g++) begin : g_entry
    rs_operand_slot #(.TW(ROB_W)) u_opa (
      .clk(clk), .rst_n(rst_n), .clr(flush),
      .src_value(a_src_val[g]), .src_tag(a_src_tag[g]),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .value_q(a_val[g]), .tag_q(a_tag[g]), .ready(a_rdy[g])
    );
    rs_operand_slot #(.TW(ROB_W)) u_opb (
      .clk(clk), .rst_n(rst_n), .clr(flush),
      .src_value(b_src_val[g]), .src_tag(b_src_tag[g]),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .value_q(b_val[g]), .tag_q(b_tag[g]), .ready(b_rdy[g])
    );

    // The top slot shifts in an empty entry on removal.
    if (g < N - 1) begin : g_nb
      assign nb_valid[g] = valid_q[g+1];
      assign nb_op[g]    = op_q[g+1];
      assign nb_dest[g]  = dest_q[g+1];
      assign nb_a_val[g] = a_val[g+1];
      assign nb_a_tag[g] = a_tag[g+1];
      assign nb_b_val[g] = b_val[g+1];
      assign nb_b_tag[g] = b_tag[g+1];
    end else begin : g_top
      assign nb_valid[g] = 1'b0;
      assign nb_op[g]    = '0;
      assign nb_dest[g]  = '0;
      assign nb_a_val[g] = '0;
      assign nb_a_tag[g] = '0;
      assign nb_b_val[g] = '0;
      assign nb_b_tag[g] = '0;
    end

    assign entry_rdy[g] = valid_q[g] & a_rdy[g] & b_rdy[g];
    assign dest_zero[g] = (dest_q[g] == ROB_W'(NO_TAG));
  end

  // Oldest ready entry: lowest slot index wins, so scan downwards.
  always_comb begin
    any_rdy  = 1'b0;
    sel_idx  = 0;
    sel_op   = '0;
    sel_opa  = '0;
    sel_opb  = '0;
    sel_dest = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (entry_rdy[i]) begin
        any_rdy  = 1'b1;
        sel_idx  = i;
        sel_op   = op_q[i];
        sel_opa  = a_val[i];
        sel_opb  = b_val[i];
        sel_dest = dest_q[i];
      end
    end
  end

  assign issue_valid   = any_rdy && !flush;
  assign issue_op      = issue_valid ? sel_op   : '0;
  assign issue_opa     = issue_valid ? sel_opa  : '0;
  assign issue_opb     = issue_valid ? sel_opb  : '0;
  assign issue_rob_tag = issue_valid ? sel_dest : '0;

  assign disp_ready = (occ_q < CW'(N)) && !flush;
  assign do_issue   = issue_valid && issue_ready;
  assign do_disp    = disp_valid && disp_ready;
  assign occupancy  = occ_q;

  always_comb begin
    wr_idx  = int'(occ_q) - (do_issue ? 1 : 0);
    valid_d = valid_q;
    for (int i = 0; i < N; i++) begin
      op_d[i]      = op_q[i];
      dest_d[i]    = dest_q[i];
      a_src_val[i] = a_val[i];
      a_src_tag[i] = a_tag[i];
      b_src_val[i] = b_val[i];
      b_src_tag[i] = b_tag[i];
      if (do_issue && i >= sel_idx) begin
        valid_d[i]   = nb_valid[i];
        op_d[i]      = nb_op[i];
        dest_d[i]    = nb_dest[i];
        a_src_val[i] = nb_a_val[i];
        a_src_tag[i] = nb_a_tag[i];
        b_src_val[i] = nb_b_val[i];
        b_src_tag[i] = nb_b_tag[i];
      end
      if (do_disp && i == wr_idx) begin
        valid_d[i]   = 1'b1;
        op_d[i]      = disp_op;
        dest_d[i]    = disp_rob_tag;
        a_src_val[i] = disp_opa_value;
        a_src_tag[i] = disp_opa_tag;
        b_src_val[i] = disp_opb_value;
        b_src_tag[i] = disp_opb_tag;
      end
      if (flush) valid_d[i] = 1'b0;
    end
    occ_d = occ_q + CW'(do_disp) - CW'(do_issue);
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < N; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < N; i++) begin
        op_q[i]   <= op_d[i];
        dest_q[i] <= dest_d[i];
      end
    end
  end

  a_occ_popcount: assert property (@(posedge clk) disable iff (!rst_n)
    occ_q == CW'($countones(valid_q)));
  a_no_zero_dest: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_q & dest_zero) == '0);

endmodule
